// File: rtl/watch_timekeeper.sv
// watch_timekeeper
//   BCD time-of-day counter driven by the 1 Hz clk_seconds square wave, with a
//   two-button set mode (mode_btn cycles RUN -> SET_HOUR -> SET_MIN -> RUN,
//   inc_btn bumps the selected field).
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   clk_seconds         1 Hz square wave, rising edge advances one second
//   mode_btn, inc_btn   debounced button levels, rising edges used
//   hours_bcd           BCD hours (00..23, or 01..12 with pm in 12h mode)
//   minutes_bcd         BCD minutes 00..59
//   seconds_bcd         BCD seconds 00..59
//   pm                  PM flag (12h mode only, else 0)
//   set_hour_active     high while setting hours
//   set_min_active      high while setting minutes
//   day_pulse           one-cycle pulse on midnight rollover
module watch_timekeeper #(
    parameter int HOUR_MODE_24 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_seconds,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [7:0] hours_bcd,
    output logic [7:0] minutes_bcd,
    output logic [7:0] seconds_bcd,
    output logic       pm,
    output logic       set_hour_active,
    output logic       set_min_active,
    output logic       day_pulse
);

    localparam bit         MODE24   = (HOUR_MODE_24 != 0);
    localparam logic [7:0] HOUR_RST = MODE24 ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;
    state_t state, state_nxt;

    // Edge detectors. Synchronizers reset high so a level already high at
    // reset release does not produce an edge.
    logic s1, s2, mode_q, inc_q;
    logic tick, mode_edge, inc_edge;

    assign tick      = s1 & ~s2;
    assign mode_edge = mode_btn & ~mode_q;
    assign inc_edge  = inc_btn & ~inc_q;

    // Plain BCD increment of a two-digit value; callers handle wrap points.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // {carry, next} for a 00..59 field.
    function automatic logic [8:0] inc60(input logic [7:0] v);
        if (v == 8'h59) return {1'b1, 8'h00};
        else            return {1'b0, bcd_inc(v)};
    endfunction

    // {pm_next, hours_next}. In 12h mode 11 -> 12 is where AM/PM flips;
    // 12 -> 01 leaves the flag alone.
    function automatic logic [8:0] inc_hour(input logic [7:0] h, input logic p);
        if (MODE24) begin
            if (h == 8'h23) return {p, 8'h00};
            else            return {p, bcd_inc(h)};
        end else begin
            if (h == 8'h12)      return {p, 8'h01};
            else if (h == 8'h11) return {~p, 8'h12};
            else                 return {p, bcd_inc(h)};
        end
    endfunction

    logic [8:0] sec_inc, min_inc, hr_inc;
    logic       at_midnight_edge;

    always_comb begin
        sec_inc = inc60(seconds_bcd);
        min_inc = inc60(minutes_bcd);
        hr_inc  = inc_hour(hours_bcd, pm);
        // Last hour of the day: 23 in 24h mode, 11 PM in 12h mode.
        at_midnight_edge = MODE24 ? (hours_bcd == 8'h23) : (hours_bcd == 8'h11 && pm);
    end

    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:      state_nxt = SET_HOUR;
                SET_HOUR: state_nxt = SET_MIN;
                default:  state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    assign set_hour_active = (state == SET_HOUR);
    assign set_min_active  = (state == SET_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b1;
            s2          <= 1'b1;
            mode_q      <= 1'b1;
            inc_q       <= 1'b1;
            hours_bcd   <= HOUR_RST;
            minutes_bcd <= 8'h00;
            seconds_bcd <= 8'h00;
            pm          <= 1'b0;
            day_pulse   <= 1'b0;
        end else begin
            s1        <= clk_seconds;
            s2        <= s1;
            mode_q    <= mode_btn;
            inc_q     <= inc_btn;
            day_pulse <= 1'b0;
            // A mode edge always wins over a tick or inc edge in the same cycle.
            case (state)
                RUN: begin
                    if (mode_edge) begin
                        seconds_bcd <= 8'h00;
                    end else if (tick) begin
                        seconds_bcd <= sec_inc[7:0];
                        if (sec_inc[8]) begin
                            minutes_bcd <= min_inc[7:0];
                            if (min_inc[8]) begin
                                hours_bcd <= hr_inc[7:0];
                                pm        <= hr_inc[8];
                                day_pulse <= at_midnight_edge;
                            end
                        end
                    end
                end
                SET_HOUR: begin
                    if (!mode_edge && inc_edge) begin
                        hours_bcd <= hr_inc[7:0];
                        pm        <= hr_inc[8];
                    end
                end
                SET_MIN: begin
                    if (!mode_edge && inc_edge) minutes_bcd <= min_inc[7:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: a 24h and a 12h instance share all inputs and
// are compared every cycle against a model that keeps time as seconds-of-day.
module tb_watch_timekeeper;

    logic clk = 1'b0;
    logic reset, clk_seconds, mode_btn, inc_btn;

    logic [7:0] h24, m24, s24, h12, m12, s12;
    logic       pm24, sh24, sm24, dp24, pm12, sh12, sm12, dp12;

    watch_timekeeper #(.HOUR_MODE_24(1)) u_dut24 (
        .clk(clk), .reset(reset), .clk_seconds(clk_seconds),
        .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hours_bcd(h24), .minutes_bcd(m24), .seconds_bcd(s24), .pm(pm24),
        .set_hour_active(sh24), .set_min_active(sm24), .day_pulse(dp24));

    watch_timekeeper #(.HOUR_MODE_24(0)) u_dut12 (
        .clk(clk), .reset(reset), .clk_seconds(clk_seconds),
        .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hours_bcd(h12), .minutes_bcd(m12), .seconds_bcd(s12), .pm(pm12),
        .set_hour_active(sh12), .set_min_active(sm12), .day_pulse(dp12));

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: time of day in seconds, mode 0=run 1=set hour 2=set min.
    int tod, st;
    bit dp, cs_d1, cs_d2, mb_d, ib_d;

    function automatic logic [7:0] bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [27:0] exp_vec(input bit mode24);
        int h, hd;
        bit p;
        h  = tod / 3600;
        hd = mode24 ? h : ((h % 12 == 0) ? 12 : h % 12);
        p  = mode24 ? 1'b0 : (h >= 12);
        return {bcd(hd), bcd((tod / 60) % 60), bcd(tod % 60), p, st == 1, st == 2, dp};
    endfunction

    task automatic model_update(input bit r, input bit cs, input bit mb, input bit ib);
        bit tk, me, ie;
        if (r) begin
            tod = 0; st = 0; dp = 0;
            cs_d1 = 1; cs_d2 = 1; mb_d = 1; ib_d = 1;
            return;
        end
        // The counter reacts one cycle after it first sees clk_seconds high.
        tk = cs_d1 && !cs_d2;
        me = mb && !mb_d;
        ie = ib && !ib_d;
        dp = 0;
        case (st)
            0: if (me) begin
                   tod = tod - tod % 60; st = 1;
               end else if (tk) begin
                   if (tod == 86399) dp = 1;
                   tod = (tod + 1) % 86400;
               end
            1: if (me) st = 2;
               else if (ie) tod = ((tod / 3600 + 1) % 24) * 3600 + tod % 3600;
            default:
               if (me) st = 0;
               else if (ie) tod = (tod / 3600) * 3600 + (((tod / 60) % 60 + 1) % 60) * 60 + tod % 60;
        endcase
        cs_d2 = cs_d1; cs_d1 = cs; mb_d = mb; ib_d = ib;
    endtask

    task automatic step(input bit r, input bit cs, input bit mb, input bit ib);
        reset = r; clk_seconds = cs; mode_btn = mb; inc_btn = ib;
        @(posedge clk);
        model_update(r, cs, mb, ib);
        #1;
        check("d24", {4'h0, h24, m24, s24, pm24, sh24, sm24, dp24}, {4'h0, exp_vec(1)});
        check("d12", {4'h0, h12, m12, s12, pm12, sh12, sm12, dp12}, {4'h0, exp_vec(0)});
    endtask

    task automatic sec_tick();
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
    endtask
    task automatic press_mode();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
    endtask
    task automatic press_inc();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
    endtask
    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
    endtask
    // Set hh:mm from a freshly reset clock and return to RUN.
    task automatic set_time(input int hh, input int mm);
        do_reset();
        press_mode();
        for (int i = 0; i < hh; i++) press_inc();
        press_mode();
        for (int i = 0; i < mm; i++) press_inc();
        press_mode();
    endtask

    initial begin
        reset = 1; clk_seconds = 0; mode_btn = 0; inc_btn = 0;
        tod = 0; st = 0; dp = 0; cs_d1 = 1; cs_d2 = 1; mb_d = 1; ib_d = 1;

        // Reset and carry
        do_reset();
        check("rst24", {h24, m24, s24, 3'(sm24 + sh24)}, 27'h0);
        check("rst12", {h12, m12, s12, pm12}, {8'h12, 8'h00, 8'h00, 1'b0});
        for (int i = 0; i < 60; i++) sec_tick();
        check("t60", {h24, m24, s24}, 24'h000100);
        for (int i = 0; i < 540; i++) sec_tick();
        check("t600", {h24, m24, s24}, 24'h001000);

        // Set mode
        do_reset();
        sec_tick();
        press_mode();
        check("set_h_act", {sh24, s24}, {1'b1, 8'h00});
        for (int i = 0; i < 3; i++) press_inc();
        sec_tick();
        check("set_h3", h24, 8'h03);
        press_mode();
        check("set_m_act", sm24, 1'b1);
        for (int i = 0; i < 61; i++) press_inc();
        sec_tick();
        check("set_m1", {h24, m24}, 16'h0301);
        press_mode();
        check("run_0301", {h24, m24, s24, sh24, sm24}, {24'h030100, 2'b00});

        // Midnight rollover, both modes
        set_time(23, 59);
        for (int i = 0; i < 59; i++) sec_tick();
        check("pre_mid", {h24, m24, s24}, 24'h235959);
        check("pre_mid12", {h12, pm12}, {8'h11, 1'b1});
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("mid24", {h24, m24, s24, dp24}, {24'h000000, 1'b1});
        check("mid12", {h12, pm12, dp12}, {8'h12, 1'b0, 1'b1});
        step(0, 0, 0, 0);
        check("dp_once", {dp24, dp12}, 2'b00);

        // 12h noon and 1 PM
        set_time(11, 59);
        for (int i = 0; i < 60; i++) sec_tick();
        check("noon12", {h12, m12, s12, pm12}, {24'h120000, 1'b1});
        press_mode();
        press_mode();
        for (int i = 0; i < 59; i++) press_inc();
        press_mode();
        for (int i = 0; i < 60; i++) sec_tick();
        check("one_pm", {h12, m12, s12, pm12}, {24'h010000, 1'b1});

        // clk_seconds held high for a long time -> one increment
        do_reset();
        for (int i = 0; i < 1000; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("held_hi", s24, 8'h01);

        // clk_seconds high through reset release -> no increment
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        check("hi_thru_rst", s24, 8'h00);
        step(0, 0, 0, 0);

        // mode and inc together in SET_HOUR
        do_reset();
        press_mode();
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        check("mode_inc", {sm24, h24}, {1'b1, 8'h00});

        // reset in SET_MIN
        do_reset();
        press_mode();
        press_mode();
        for (int i = 0; i < 42; i++) press_inc();
        check("min42", m24, 8'h42);
        step(1, 0, 0, 0);
        check("rst_mid", {h24, m24, s24, sm24, sh24}, 26'h0);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
